fetch_mem_arbiter: RTL

Single-port memory bus arbiter that shares the core's one external memory port between the instruction-fetch requester (PrePc/I-Cache refill path) and the data requester (load/store stage). A three-state FSM grants one requester at a time, registers its request onto the bus, routes the bus response back as a one-cycle acknowledge (the fetch acknowledge drives `ReadShakeHands`), discards fetches cancelled by a pipeline flush, and terminates hung transactions with a watchdog error. It sits between PrePc/Lsu and the bus interface.

---
 rtl/fetch_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_mem_arbiter.sv
// Shares the single external memory port between instruction fetch and load/store.
// Grants alternate on ties; flushed fetches complete silently; a watchdog ends hung transactions.
module fetch_mem_arbiter #(
   parameter int AddrWidth     = 64,
   parameter int DataWidth     = 64,
   parameter int InstWidth     = 32,
   parameter int TimeoutCycles = 255
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     IReq,
   input  logic [AddrWidth-1:0]     IAddr,
   input  logic                     IFlush,
   output logic                     IAck,
   output logic [InstWidth-1:0]     IData,
   output logic                     IErr,
   input  logic                     DReq,
   input  logic                     DWe,
   input  logic [AddrWidth-1:0]     DAddr,
   input  logic [DataWidth-1:0]     DWData,
   input  logic [DataWidth/8-1:0]   DMask,
   output logic                     DAck,
   output logic [DataWidth-1:0]     DRData,
   output logic                     DErr,
   output logic                     BusReq,
   output logic                     BusWe,
   output logic [AddrWidth-1:0]     BusAddr,
   output logic [DataWidth-1:0]     BusWData,
   output logic [DataWidth/8-1:0]   BusMask,
   input  logic                     BusAck,
   input  logic [DataWidth-1:0]     BusRData
);

   localparam int         MaskWidth = DataWidth / 8;
   localparam logic [7:0] WdogLast  = 8'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_I_BUSY = 2'd1,
      ST_D_BUSY = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_last_d;
   logic                   r_discard;
   logic [7:0]             r_wdog;
   logic                   r_bus_req;
   logic                   r_bus_we;
   logic [AddrWidth-1:0]   r_bus_addr;
   logic [DataWidth-1:0]   r_bus_wdata;
   logic [MaskWidth-1:0]   r_bus_mask;

   logic                   w_idle;
   logic                   w_busy;
   logic                   w_i_elig;
   logic                   w_d_elig;
   logic                   w_grant_i;
   logic                   w_grant_d;
   logic                   w_timeout;
   logic                   w_done;
   logic                   w_suppress;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_busy    = (r_state == ST_I_BUSY) || (r_state == ST_D_BUSY);
   assign w_i_elig  = IReq & ~IFlush;
   assign w_d_elig  = DReq;
   // On a tie the requester that did not own the bus last time wins.
   assign w_grant_i = w_idle & w_i_elig & (~w_d_elig | r_last_d);
   assign w_grant_d = w_idle & w_d_elig & (~w_i_elig | ~r_last_d);
   assign w_timeout = w_busy & ~BusAck & (r_wdog == WdogLast);
   assign w_done    = w_busy & (BusAck | w_timeout);
   assign w_suppress = r_discard | IFlush;

   assign BusReq   = r_bus_req;
   assign BusWe    = r_bus_we;
   assign BusAddr  = r_bus_addr;
   assign BusWData = r_bus_wdata;
   assign BusMask  = r_bus_mask;

   // Next-state selection for the grant/busy FSM
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d) begin
               w_next_state = ST_D_BUSY;
            end else if (w_grant_i) begin
               w_next_state = ST_I_BUSY;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_I_BUSY, ST_D_BUSY: begin
            if (w_done) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = r_state;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Completion strobes and returned data, routed only to the current owner
   always_comb begin
      IAck   = (r_state == ST_I_BUSY) & BusAck & ~w_suppress;
      IErr   = (r_state == ST_I_BUSY) & w_timeout & ~w_suppress;
      DAck   = (r_state == ST_D_BUSY) & BusAck;
      DErr   = (r_state == ST_D_BUSY) & w_timeout;
      IData  = {InstWidth{1'b0}};
      DRData = {DataWidth{1'b0}};
      if (IAck) begin
         IData = r_bus_addr[2] ? BusRData[2*InstWidth-1:InstWidth] : BusRData[InstWidth-1:0];
      end else begin
         IData = {InstWidth{1'b0}};
      end
      if (DAck) begin
         DRData = BusRData;
      end else begin
         DRData = {DataWidth{1'b0}};
      end
   end

   // State, bus payload, owner history, flush discard and watchdog registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state     <= ST_IDLE;
         r_last_d    <= 1'b0;
         r_discard   <= 1'b0;
         r_wdog      <= 8'd0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= {AddrWidth{1'b0}};
         r_bus_wdata <= {DataWidth{1'b0}};
         r_bus_mask  <= {MaskWidth{1'b0}};
      end else begin
         r_state <= w_next_state;
         if (w_grant_d) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= DWe;
            r_bus_addr  <= DAddr;
            r_bus_wdata <= DWData;
            r_bus_mask  <= DMask;
            r_last_d    <= 1'b1;
            r_wdog      <= 8'd0;
            r_discard   <= 1'b0;
         end else if (w_grant_i) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= IAddr;
            r_bus_wdata <= {DataWidth{1'b0}};
            r_bus_mask  <= {MaskWidth{1'b0}};
            r_last_d    <= 1'b0;
            r_wdog      <= 8'd0;
            r_discard   <= 1'b0;
         end else if (w_done) begin
            r_bus_req <= 1'b0;
         end else if (w_busy) begin
            r_wdog <= r_wdog + 8'd1;
            if ((r_state == ST_I_BUSY) && IFlush) begin
               r_discard <= 1'b1;
            end
         end
      end
   end

endmodule
